error_comp_pipe: RTL
====================

# error_comp_pipe

Pipelined, parametrised error-compensation combiner for the approximate unsigned multiplier datapath. It takes NT partial error terms, drops TRUNC low bits from each, and aligns term i at bit offset i. The terms are then reduced through a registered binary tree, either by bitwise OR (approximate, low power) or by exact addition, selected per transaction. It sits between the partial-product error generators and the final compensation adder, and replaces the fixed 7-term combinational OR combiner.

## Interface
- EW, default 9: width of each error term.
- NT, default 7: number of error terms, 2..16.
- TRUNC, default 2: LSBs dropped from each term, 0..EW-1.
- OW (derived, not overridable), EW-TRUNC+NT-1: OR-mode result width; 13 at defaults.
- OWA (derived), OW+clog2(NT): output width; 16 at defaults.
- clk  in  1: clock; all state on rising edge.
- rst  in  1: reset, asynchronous, active-high.
- in_valid  in  1: input transaction valid.
- in_ready  out  1: block accepts input this cycle.
- in_mode  in  1: 0 = OR reduction, 1 = ADD reduction.
- in_terms  in  NT*EW: packed terms; term i is in_terms[i*EW +: EW].
- out_valid  out  1: result valid.
- out_ready  in  1: downstream accepts result.
- out_mode  out  1: mode of the result, carried with the data.
- out_data  out  OWA: compensation value, zero-extended in OR mode.

## Operation
- Stage 0 (align):
  - t_i = in_terms[i] >> TRUNC, zero-extended to OWA and shifted left by i.
  - The aligned terms and the mode are registered.
- Stages 1..D, D = clog2(NT):
  - Tree level l combines nodes 2j and 2j+1 of level l-1 with OR or + per the carried mode.
  - An odd leftover node passes through unchanged. Each level is registered.
- Result:
  - OR mode: out_data = OR of all t_i. Bits OWA-1..OW are always 0.
  - ADD mode: out_data = sum of all t_i. This is exact and never overflows OWA.
- Global stall:
  - stall = out_valid & ~out_ready.
  - While stalled, every pipeline register, valid bit and mode bit holds.
  - in_ready = ~stall, combinational.
- Bubbles are not compressed. Each stage carries its own valid bit.
- The mode travels with each transaction, so back-to-back transactions may alternate modes.
- Input is accepted when in_valid & in_ready. A result transfers when out_valid & out_ready.
- in_terms and in_mode are ignored when not accepted.

## Timing
- Latency L = D+1 cycles from acceptance to out_valid; 4 at defaults. Throughput is one result per cycle when unstalled.
- Reset values:
  - All valid bits, out_valid and out_mode are 0.
  - out_data is 0.
  - in_ready is 1 after reset, since out_valid = 0.
- Reset mid-operation flushes all in-flight transactions; none are emitted after reset deasserts.
- out_data and out_mode are stable while out_valid & ~out_ready.
- in_valid & in_ready in the same cycle as out_valid & out_ready: both transfers occur and the pipeline advances.

## Configuration
- ERRC_STATS_EN:
  - When defined, adds ports stat_clr (in, 1), stat_cnt (out, 32) and stat_nz (out, 32).
  - stat_cnt counts transferred results. stat_nz counts transferred results with out_data != 0.
  - Both counters saturate at 32'hFFFF_FFFF. Both reset to 0 on rst.
  - stat_clr zeroes both counters on the next edge and wins over a same-cycle increment.
- When undefined, these ports and registers do not exist, and the block has no other behavioural difference.

## Structure
- Package errc_pkg holds:
  - the mode typedef: ERRC_OR = 1'b0, ERRC_ADD = 1'b1;
  - width helper functions errc_ow(EW,NT,TRUNC) and errc_owa(EW,NT,TRUNC);
  - the counter width constant ERRC_STAT_W = 32.
- Sub-module errc_node is one registered tree node:
  - inputs a, b, mode, valid, en;
  - passthrough option for the odd leftover.
- The top module generates the D levels of errc_node instances.

## Test plan
Defaults EW=9, NT=7, TRUNC=2 for all cases.

- All terms 9'h1FF, OR mode -> out_data 16'h1FFF after 4 cycles; out_mode 0.
- All terms 9'h1FF, ADD mode -> out_data 16'h3F01 (127×127).
- Only term 2 = 9'h004, others 0 -> 16'h0004 in both modes. Term 0 = 9'h003, others 0 -> 16'h0000 (truncated away).
- Back-to-back stream alternating OR/ADD with random terms, out_ready held 1 -> one result per cycle, in order, each matching the reference model for its own mode.
- out_ready low for 5 cycles with in_valid high:
  - in_ready drops the cycle out_valid rises;
  - out_data holds;
  - no loss or duplication after release.
- rst pulsed with 3 transactions in flight -> all outputs 0 immediately and no stale results afterward. With ERRC_STATS_EN defined, counters read 0; then 2 transfers (one zero) give stat_cnt=2, stat_nz=1.

Source files
------------

// File: rtl/errc_pkg.sv
// Shared types, width helpers and constants for the error-compensation combiner.
package errc_pkg;

    typedef enum logic {
        ERRC_OR  = 1'b0,
        ERRC_ADD = 1'b1
    } errc_mode_e;

    localparam int ERRC_STAT_W = 32;

    // Width of an OR-reduced result: truncated term width plus the largest alignment shift.
    function automatic int errc_ow(input int ew, input int nt, input int trunc);
        return ew - trunc + nt - 1;
    endfunction

    // Extra clog2(nt) bits guarantee the exact sum of all terms always fits.
    function automatic int errc_owa(input int ew, input int nt, input int trunc);
        return errc_ow(ew, nt, trunc) + $clog2(nt);
    endfunction

    // Number of live nodes at tree level lvl (level 0 holds the nt aligned terms).
    function automatic int errc_nodes(input int nt, input int lvl);
        return (nt + (1 << lvl) - 1) >> lvl;
    endfunction

endpackage

// File: rtl/errc_node.sv
// One registered reduction-tree node: OR or ADD of two children, or a plain
// register for the odd leftover node when PASS is set.
module errc_node
    import errc_pkg::*;
#(
    parameter int W    = 16,
    parameter bit PASS = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         valid_i,
    input  errc_mode_e   mode_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] y_o
);

    logic [W-1:0] y_d;
    logic [W-1:0] y_q;

    always_comb begin
        y_d = a_i | b_i;
        if (PASS) begin
            y_d = a_i;
        end else if (mode_i == ERRC_ADD) begin
            y_d = a_i + b_i;
        end
    end

    // Data only moves with a valid token, so bubbles leave the register untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q <= '0;
        end else if (en_i && valid_i) begin
            y_q <= y_d;
        end
    end

    assign y_o = y_q;

endmodule

// File: rtl/error_comp_pipe.sv
// Pipelined error-compensation combiner: align/truncate stage followed by a registered
// OR/ADD binary tree. Define ERRC_STATS_EN to add transfer/non-zero result counters.
module error_comp_pipe
    import errc_pkg::*;
#(
    parameter  int EW    = 9,
    parameter  int NT    = 7,
    parameter  int TRUNC = 2,
    localparam int OW    = errc_ow(EW, NT, TRUNC),
    localparam int OWA   = errc_owa(EW, NT, TRUNC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mode,
    input  logic [NT*EW-1:0]  in_terms,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_mode,
    output logic [OWA-1:0]    out_data
`ifdef ERRC_STATS_EN
    ,
    input  logic                   stat_clr,
    output logic [ERRC_STAT_W-1:0] stat_cnt,
    output logic [ERRC_STAT_W-1:0] stat_nz
`endif
);

    localparam int D = $clog2(NT);

    // Valid/ready contract: a token moves into stage 0 when in_valid & in_ready and
    // leaves the last stage when out_valid & out_ready. A blocked output freezes
    // every stage at once, so in_ready is simply the inverse of that stall.
    logic stall;
    logic en;

    assign stall    = out_valid & ~out_ready;
    assign en       = ~stall;
    assign in_ready = en;

    logic [OWA-1:0] align_d [NT];
    logic [OWA-1:0] align_q [NT];

    always_comb begin
        for (int i = 0; i < NT; i++) begin
            align_d[i] = OWA'(in_terms[i*EW +: EW] >> TRUNC) << i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NT; i++) begin
                align_q[i] <= '0;
            end
        end else if (en && in_valid) begin
            for (int i = 0; i < NT; i++) begin
                align_q[i] <= align_d[i];
            end
        end
    end

    // One valid and one mode bit per level; the mode rides along with its token.
    logic [D:0] vld_d;
    logic [D:0] vld_q;
    logic [D:0] mode_d;
    logic [D:0] mode_q;

    always_comb begin
        vld_d  = {vld_q[D-1:0], in_valid};
        mode_d = {mode_q[D-1:0], (in_valid ? in_mode : mode_q[0])};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '0;
            mode_q <= '0;
        end else if (en) begin
            vld_q  <= vld_d;
            mode_q <= mode_d;
        end
    end

    logic [OWA-1:0] lvl [0:D][0:NT-1];

    genvar gi, gl, gj;
    generate
        for (gi = 0; gi < NT; gi++) begin : g_lvl0
            assign lvl[0][gi] = align_q[gi];
        end

        for (gl = 1; gl <= D; gl++) begin : g_level
            for (gj = 0; gj < NT; gj++) begin : g_node
                if (gj < errc_nodes(NT, gl)) begin : g_live
                    if (2*gj + 1 < errc_nodes(NT, gl - 1)) begin : g_pair
                        errc_node #(
                            .W    (OWA),
                            .PASS (1'b0)
                        ) u_node (
                            .clk     (clk),
                            .rst     (rst),
                            .en_i    (en),
                            .valid_i (vld_q[gl-1]),
                            .mode_i  (errc_mode_e'(mode_q[gl-1])),
                            .a_i     (lvl[gl-1][2*gj]),
                            .b_i     (lvl[gl-1][2*gj+1]),
                            .y_o     (lvl[gl][gj])
                        );
                    end else begin : g_pass
                        errc_node #(
                            .W    (OWA),
                            .PASS (1'b1)
                        ) u_node (
                            .clk     (clk),
                            .rst     (rst),
                            .en_i    (en),
                            .valid_i (vld_q[gl-1]),
                            .mode_i  (errc_mode_e'(mode_q[gl-1])),
                            .a_i     (lvl[gl-1][2*gj]),
                            .b_i     ({OWA{1'b0}}),
                            .y_o     (lvl[gl][gj])
                        );
                    end
                end else begin : g_dead
                    assign lvl[gl][gj] = '0;
                end
            end
        end
    endgenerate

    assign out_valid = vld_q[D];
    assign out_mode  = mode_q[D];
    assign out_data  = lvl[D][0];

`ifdef ERRC_STATS_EN
    logic                   xfer;
    logic [ERRC_STAT_W-1:0] stat_cnt_q;
    logic [ERRC_STAT_W-1:0] stat_nz_q;

    assign xfer = out_valid & out_ready;

    // Clear takes priority over a same-cycle increment; both counters saturate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_cnt_q <= '0;
            stat_nz_q  <= '0;
        end else if (stat_clr) begin
            stat_cnt_q <= '0;
            stat_nz_q  <= '0;
        end else if (xfer) begin
            if (stat_cnt_q != '1) begin
                stat_cnt_q <= stat_cnt_q + 1'b1;
            end
            if ((out_data != '0) && (stat_nz_q != '1)) begin
                stat_nz_q <= stat_nz_q + 1'b1;
            end
        end
    end

    assign stat_cnt = stat_cnt_q;
    assign stat_nz  = stat_nz_q;
`endif

endmodule
